miner_host_if: RTL and testbench



---
 rtl/miner_host_if_pkg.sv | 25 ++
 rtl/miner_host_if_nonce_fifo.sv | 50 +++++
 rtl/miner_host_if.sv | 121 ++++++++++++
 tb/tb_miner_host_if.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/miner_host_if_pkg.sv
// Shared constants and helpers for the miner host interface: record sizes,
// status-byte layout and the "no nonce" marker.
package miner_pkg;

    localparam int WORK_BYTES    = 44;
    localparam int RECORD_BYTES  = 9;
    localparam int WORK_BITS     = WORK_BYTES * 8;
    localparam int MIDSTATE_BITS = 256;
    localparam int NONCE_BITS    = 32;

    localparam int STATUS_OVF_BIT   = 7;
    localparam int STATUS_LEVEL_LSB = 0;
    localparam int STATUS_LEVEL_W   = 4;

    localparam logic [NONCE_BITS-1:0] GOLDEN_NONE = 32'd0;

    function automatic logic [7:0] status_byte(input logic ovf, input logic [STATUS_LEVEL_W-1:0] level);
        logic [7:0] s;
        s = '0;
        s[STATUS_OVF_BIT] = ovf;
        s[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = level;
        return s;
    endfunction

endpackage

// File: rtl/miner_host_if_nonce_fifo.sv
// Golden-nonce FIFO: power-of-two depth, simultaneous push/pop allowed even
// when full, 4-bit occupancy output.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       level,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == 4'(DEPTH));
    assign empty   = (level == 4'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + 4'(do_push) - 4'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/miner_host_if.sv
// Host side of the miner: byte-serial work assembly with commit-triggered
// miner reset, golden-nonce capture, and a byte-serial status/nonce read stream.
module miner_host_if
    import miner_pkg::*;
#(
    parameter int NONCE_FIFO_DEPTH = 4,
    parameter int RESET_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_strobe,
    input  logic [7:0]   wr_data,
    input  logic         rd_strobe,
    output logic [7:0]   rd_data,
    output logic [255:0] midstate,
    output logic [95:0]  data,
    output logic         miner_reset,
    input  logic [31:0]  golden_nonce,
    input  logic [31:0]  nonce2,
    output logic         overflow,
    output logic [3:0]   fifo_level
);
    logic [WORK_BITS-1:0]  shadow;
    logic [WORK_BITS-1:0]  shadow_next;
    logic [5:0]            wr_idx;
    logic                  commit;
    logic [3:0]            rst_cnt;

    logic [NONCE_BITS-1:0] gn_d;
    logic                  push;
    logic                  pop;
    logic [NONCE_BITS-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [3:0]            rd_idx;
    logic                  snap_valid;
    logic [NONCE_BITS-1:0] snap_nonce;
    logic [NONCE_BITS-1:0] snap_n2;
    logic [63:0]           snap_rec;
    logic [2:0]            byte_sel;

    assign commit      = wr_strobe && (wr_idx == 6'(WORK_BYTES - 1));
    assign miner_reset = (rst_cnt != 4'd0);
    assign push        = (golden_nonce != gn_d) && (golden_nonce != GOLDEN_NONE) && !miner_reset;
    assign pop         = rd_strobe && (rd_idx == 4'(RECORD_BYTES - 1)) && snap_valid;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (no latch inferred).
    always_comb begin
        shadow_next = shadow;
        if (wr_strobe) shadow_next[{wr_idx, 3'b000} +: 8] = wr_data;
    end

    // NOTE: all state below updates with non-blocking '<=' so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            wr_idx   <= '0;
            midstate <= '0;
            data     <= '0;
            rst_cnt  <= 4'(RESET_CYCLES);
            overflow <= 1'b0;
            gn_d     <= '0;
        end else begin
            shadow <= shadow_next;
            gn_d   <= golden_nonce;
            if (wr_strobe) wr_idx <= commit ? 6'd0 : wr_idx + 6'd1;
            if (commit) begin
                {data, midstate} <= shadow_next;
                rst_cnt          <= 4'(RESET_CYCLES);
            end else if (rst_cnt != 4'd0) begin
                rst_cnt <= rst_cnt - 4'd1;
            end
            // A drop in the commit cycle wins over the commit's clear.
            if (push && fifo_full && !pop) overflow <= 1'b1;
            else if (commit)               overflow <= 1'b0;
        end
    end

    nonce_fifo #(
        .WIDTH (NONCE_BITS),
        .DEPTH (NONCE_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (golden_nonce),
        .dout  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_idx     <= '0;
            snap_valid <= 1'b0;
            snap_nonce <= '0;
            snap_n2    <= '0;
        end else if (rd_strobe) begin
            if (rd_idx == 4'd0) begin
                snap_valid <= !fifo_empty;
                snap_nonce <= fifo_empty ? GOLDEN_NONE : fifo_head;
                snap_n2    <= nonce2;
            end
            rd_idx <= (rd_idx == 4'(RECORD_BYTES - 1)) ? 4'd0 : rd_idx + 4'd1;
        end
    end

    assign snap_rec = {snap_n2, snap_nonce};
    assign byte_sel = 3'(rd_idx - 4'd1);

    always_comb begin
        rd_data = status_byte(overflow, fifo_level);
        if (rd_idx != 4'd0) rd_data = snap_rec[{byte_sel, 3'b000} +: 8];
    end

endmodule

// File: tb/tb_miner_host_if.sv
// Self-checking bench for miner_host_if: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_miner_host_if;
    localparam int DEPTH = 4;
    localparam int R     = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_strobe;
    logic [7:0]   wr_data;
    logic         rd_strobe;
    logic [7:0]   rd_data;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         miner_reset;
    logic [31:0]  golden_nonce;
    logic [31:0]  nonce2;
    logic         overflow;
    logic [3:0]   fifo_level;

    miner_host_if #(.NONCE_FIFO_DEPTH(DEPTH), .RESET_CYCLES(R)) dut (
        .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_data(wr_data),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .midstate(midstate), .data(data),
        .miner_reset(miner_reset), .golden_nonce(golden_nonce), .nonce2(nonce2),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: byte list for the work record, a queue for the FIFO,
    // a 9-byte snapshot record, and a timestamp for the miner reset window.
    logic [7:0]   m_bytes [44];
    logic [351:0] m_work;
    int           m_widx, m_ridx;
    bit           m_ovf, m_snap_valid;
    logic [31:0]  m_snap_nonce, m_snap_n2, m_prev_gn;
    logic [31:0]  m_q [$];
    int unsigned  cyc = 0, win_start = 0;

    function automatic bit m_mr();
        return (cyc - win_start) < R;
    endfunction

    function automatic logic [7:0] m_rd();
        if (m_ridx == 0)      return {m_ovf, 3'b000, 4'(m_q.size())};
        else if (m_ridx <= 4) return 8'(m_snap_nonce >> (8 * (m_ridx - 1)));
        else                  return 8'(m_snap_n2 >> (8 * (m_ridx - 5)));
    endfunction

    task automatic model_edge();
        bit mr, push, pop;
        mr = m_mr();
        cyc++;
        if (reset) begin
            foreach (m_bytes[k]) m_bytes[k] = 8'h00;
            m_work = '0; m_widx = 0; m_ridx = 0; m_ovf = 0; m_snap_valid = 0;
            m_snap_nonce = 0; m_snap_n2 = 0; m_prev_gn = 0; m_q.delete();
            win_start = cyc;
            return;
        end
        push = (golden_nonce != m_prev_gn) && (golden_nonce != 0) && !mr;
        pop  = 0;
        if (rd_strobe) begin
            if (m_ridx == 0) begin
                m_snap_valid = (m_q.size() != 0);
                m_snap_nonce = m_snap_valid ? m_q[0] : 32'd0;
                m_snap_n2    = nonce2;
            end
            if (m_ridx == 8) pop = m_snap_valid;
            m_ridx = (m_ridx == 8) ? 0 : m_ridx + 1;
        end
        if (wr_strobe) begin
            m_bytes[m_widx] = wr_data;
            if (m_widx == 43) begin
                for (int k = 0; k < 44; k++) m_work[8*k +: 8] = m_bytes[k];
                m_widx = 0; m_ovf = 0; win_start = cyc;
            end else begin
                m_widx++;
            end
        end
        m_prev_gn = golden_nonce;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(golden_nonce);
            else m_ovf = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("m_rd_data", rd_data, m_rd());
        check("m_work", {data, midstate}, m_work);
        check("m_miner_reset", miner_reset, m_mr());
        check("m_overflow", overflow, m_ovf);
        check("m_fifo_level", fifo_level, 4'(m_q.size()));
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_strobe = 1'b1; wr_data = b; step(); wr_strobe = 1'b0;
    endtask

    logic [7:0] got_rec [9];
    logic [7:0] exp_rec [9];

    task automatic rd_byte(input int i);
        got_rec[i] = rd_data; rd_strobe = 1'b1; step(); rd_strobe = 1'b0;
    endtask

    task automatic rd_record();
        for (int i = 0; i < 9; i++) rd_byte(i);
    endtask

    task automatic commit_work(input logic [7:0] base);
        for (int k = 0; k < 44; k++) wr_byte(8'(base + k));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wr_strobe = 0; wr_data = 0; rd_strobe = 0;
        golden_nonce = 0; nonce2 = 0;
        step(); step();
        reset = 1'b0;
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_miner_reset", miner_reset, 1'b1);
        check("rst_level", fifo_level, 4'd0);
        check("rst_midstate", midstate, 256'd0);

        // Work load 0x00..0x2B
        for (int k = 0; k < 43; k++) wr_byte(8'(k));
        check("partial_midstate", midstate, 256'd0);
        check("partial_data", data, 96'd0);
        wr_byte(8'h2B);
        check("ms_byte0", midstate[7:0], 8'h00);
        check("ms_byte31", midstate[255:248], 8'h1F);
        check("data_byte11", data[95:88], 8'h2B);
        check("mr_cycle1", miner_reset, 1'b1);
        step();
        check("mr_cycle2", miner_reset, 1'b1);
        step();
        check("mr_released", miner_reset, 1'b0);

        // Single nonce report
        nonce2 = 32'hAABBCCDD; golden_nonce = 32'h12345678;
        step();
        check("one_level", fifo_level, 4'd1);
        exp_rec = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rd_record();
        for (int i = 0; i < 9; i++) check($sformatf("one_rec[%0d]", i), got_rec[i], exp_rec[i]);
        check("one_level_after", fifo_level, 4'd0);

        // Overflow with five nonces
        for (int i = 0; i < 5; i++) begin golden_nonce = 32'h11 + i; step(); end
        check("ovf_level", fifo_level, 4'd4);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_status", rd_data, 8'h84);
        for (int r = 0; r < 4; r++) begin
            rd_record();
            check($sformatf("ovf_nonce%0d", r), got_rec[1], 8'(8'h11 + r));
        end
        commit_work(8'h40);
        check("ovf_cleared", overflow, 1'b0);
        step(); step();

        // Empty read
        exp_rec = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rd_record();
        for (int i = 0; i < 9; i++) check($sformatf("empty_rec[%0d]", i), got_rec[i], exp_rec[i]);
        check("empty_level", fifo_level, 4'd0);

        // Push on the popping strobe while full
        for (int i = 0; i < 4; i++) begin golden_nonce = 32'h21 + i; step(); end
        check("full_level", fifo_level, 4'd4);
        for (int i = 0; i < 8; i++) rd_byte(i);
        golden_nonce = 32'h25;
        rd_byte(8);
        check("pushpop_level", fifo_level, 4'd4);
        check("pushpop_ovf", overflow, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rd_record();
            check($sformatf("pushpop_nonce%0d", r), got_rec[1], 8'(8'h22 + r));
        end

        // Mid-operation reset
        for (int k = 0; k < 20; k++) wr_byte(8'($urandom));
        golden_nonce = 32'h99; step();
        for (int i = 0; i < 3; i++) rd_byte(i);
        reset = 1'b1; step(); reset = 1'b0;
        check("midrst_rd_data", rd_data, 8'h00);
        check("midrst_level", fifo_level, 4'd0);
        commit_work(8'h80);
        check("midrst_ms0", midstate[7:0], 8'h80);
        check("midrst_d11", data[95:88], 8'hAB);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            wr_strobe = ($urandom_range(0, 2) == 0);
            wr_data   = 8'($urandom);
            rd_strobe = ($urandom_range(0, 2) == 0);
            nonce2    = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: golden_nonce = 32'd0;
                    1: golden_nonce = 32'($urandom_range(1, 6));
                    default: golden_nonce = $urandom;
                endcase
            end
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 0; wr_strobe = 0; rd_strobe = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
